sdr_req_arbiter: RTL and testbench
==================================

// Module: sdr_req_arbiter
// PURPOSE
//  Two-requester arbiter between the CPU-side SDRAM request port and the DMA request port of
//  the FIR DMA engine, feeding a single SDRAM controller command port.
//  Serves one request at a time, with no outstanding overlap.
//  Returns a one-cycle ack (and read data) to the granted requester only.
//  Sits directly downstream of the DMA engine's dma_req_*/dma_rsp_* interface.
// PARAMETERS
//  ADDR_W    23  request/SDRAM word-byte address width
//  DATA_W    32  data width
//  DMA_PRIO  0   0: round-robin on conflict; 1: DMA always wins conflict
// PORTS
//  clk            in   1       clock
//  rst_n          in   1       reset, asynchronous, active-low
//  cpu_req_valid  in   1       CPU request; held until cpu_req_ack
//  cpu_req_addr   in   ADDR_W  CPU address
//  cpu_req_rw     in   1       1=write, 0=read
//  cpu_req_wdata  in   DATA_W  CPU write data
//  cpu_req_ack    out  1       one-cycle completion pulse to CPU
//  cpu_rsp_rdata  out  DATA_W  read data, valid in cpu_req_ack cycle
//  dma_req_valid  in   1       DMA request; held until dma_req_ack
//  dma_req_addr   in   ADDR_W  DMA address
//  dma_req_rw     in   1       1=write, 0=read
//  dma_req_wdata  in   DATA_W  DMA write data
//  dma_req_ack    out  1       one-cycle completion pulse to DMA
//  dma_rsp_rdata  out  DATA_W  read data, valid in dma_req_ack cycle
//  sdr_in_valid   out  1       command valid to SDRAM controller
//  sdr_addr       out  ADDR_W  command address
//  sdr_rw         out  1       command direction
//  sdr_wdata      out  DATA_W  command write data
//  sdr_ready      in   1       controller accepts command when sdr_in_valid && sdr_ready
//  sdr_out_valid  in   1       one-cycle read-data-return strobe
//  sdr_rdata      in   DATA_W  read return data
//  gnt_dma        out  1       1 while the current/last grant is the DMA (debug)
// BEHAVIOUR
//  Reset: state IDLE.
//   - All outputs 0: acks, sdr_in_valid, sdr_addr, sdr_rw, sdr_wdata, rsp_rdata, gnt_dma.
//   - last_grant = CPU, so the first conflict goes to the DMA.
//  FSM states: IDLE, ISSUE, WAIT_RD, ACK.
//   IDLE: if any valid -> latch winner's addr/rw/wdata, set gnt_dma, assert sdr_in_valid (registered) -> ISSUE.
//     Conflict: DMA_PRIO=1 -> DMA; else the requester != last_grant; update last_grant.
//   ISSUE: hold sdr_in_valid and the command stable until sdr_ready.
//     On accept: drop sdr_in_valid next cycle; rw=1 -> ACK; rw=0 -> WAIT_RD.
//   WAIT_RD: on sdr_out_valid, capture sdr_rdata into the shared rdata register -> ACK.
//   ACK: pulse only the granted requester's ack for exactly 1 cycle -> IDLE.
//  Data return:
//   - cpu_rsp_rdata and dma_rsp_rdata both drive from the shared rdata register.
//   - The register holds its value until the next read capture; writes leave it unchanged.
//  Latency:
//   - Write, sdr_ready already high: valid@0 -> sdr_in_valid@1 -> ack@2.
//   - Read: ack is one cycle after sdr_out_valid.
//  Request validity:
//   - Requester valid is not re-sampled in ACK, so a still-high old valid is never double-granted.
//   - A valid seen in the IDLE cycle after ACK is a new request, so back-to-back DMA streaming sustains 1 op per 3+ cycles.
//  Stray strobes: sdr_out_valid in IDLE/ISSUE/ACK is ignored.
//  Unanticipated deassertion: a requester dropping valid before its ack is a protocol violation.
//   - The latched command still completes and acks.
//  Reset mid-operation: immediate return to IDLE, all outputs cleared, any in-flight read discarded.
//  Widths: no arithmetic; address and data pass through unmodified.
// TESTING
//  T1 DMA read only:
//   - Stimulus: addr 0x000100, controller returns 0xDEADBEEF 3 cycles after accept.
//   - Required: dma_req_ack 1 cycle, dma_rsp_rdata=0xDEADBEEF, cpu_req_ack stays 0.
//  T2 CPU write with sdr_ready=1:
//   - Stimulus: addr 0x000040, data 0x12345678.
//   - Required: sdr_in_valid@1 carrying that addr/data with sdr_rw=1; cpu_req_ack@2.
//  T3 Conflict, DMA_PRIO=0:
//   - Stimulus: both requesters valid continuously for 4 ops.
//   - Required: grant order DMA, CPU, DMA, CPU.
//   - Repeat with DMA_PRIO=1: DMA only, CPU starves while DMA valid.
//  T4 Back-pressure:
//   - Stimulus: sdr_ready low 5 cycles.
//   - Required: sdr_in_valid and command held stable for all 5 cycles, exactly one accept.
//  T5 DMA streaming:
//   - Stimulus: valid kept high with a new address the cycle after each ack, 8 reads.
//   - Required: 8 distinct sdr commands, 8 acks, no duplicate grant.
//  T6 Reset during WAIT_RD:
//   - Stimulus: rst_n low, then a late sdr_out_valid.
//   - Required: outputs 0, late strobe ignored, no ack.

Source files
------------

// File: rtl/sdr_req_arbiter.sv
// -----------------------------------------------------------------------------
// sdr_req_arbiter
//   Two-requester arbiter placing CPU-side and DMA-side SDRAM requests onto a
//   single SDRAM controller command port. Exactly one request is in flight at
//   a time. The granted requester alone receives a one-cycle ack. For reads,
//   the data is valid in the same cycle as that ack.
//
//   Parameters
//     ADDR_W    address width (passed through unmodified)
//     DATA_W    data width (passed through unmodified)
//     DMA_PRIO  0: round-robin on conflict, 1: DMA always wins a conflict
//
//   Ports
//     clk, rst_n                          clock, async active-low reset
//     cpu_req_valid/addr/rw/wdata         CPU request, held until cpu_req_ack
//     cpu_req_ack, cpu_rsp_rdata          CPU completion pulse + read data
//     dma_req_valid/addr/rw/wdata         DMA request, held until dma_req_ack
//     dma_req_ack, dma_rsp_rdata          DMA completion pulse + read data
//     sdr_in_valid/addr/rw/wdata          command to SDRAM controller
//     sdr_ready                           controller accepts when valid&&ready
//     sdr_out_valid, sdr_rdata            one-cycle read return strobe + data
//     gnt_dma                             1 while current/last grant is DMA
// -----------------------------------------------------------------------------
module sdr_req_arbiter #(
    parameter int ADDR_W   = 23,
    parameter int DATA_W   = 32,
    parameter int DMA_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cpu_req_valid,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic              cpu_req_rw,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_req_ack,
    output logic [DATA_W-1:0] cpu_rsp_rdata,

    input  logic              dma_req_valid,
    input  logic [ADDR_W-1:0] dma_req_addr,
    input  logic              dma_req_rw,
    input  logic [DATA_W-1:0] dma_req_wdata,
    output logic              dma_req_ack,
    output logic [DATA_W-1:0] dma_rsp_rdata,

    output logic              sdr_in_valid,
    output logic [ADDR_W-1:0] sdr_addr,
    output logic              sdr_rw,
    output logic [DATA_W-1:0] sdr_wdata,
    input  logic              sdr_ready,
    input  logic              sdr_out_valid,
    input  logic [DATA_W-1:0] sdr_rdata,

    output logic              gnt_dma
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT_RD = 2'd2;
    localparam logic [1:0] ACK     = 2'd3;

    logic [1:0]        state;
    logic [DATA_W-1:0] rdata_q;
    logic              pick_dma;

    // gnt_dma doubles as the round-robin "last grant" flag: it resets to CPU,
    // so the first conflict after reset goes to the DMA.
    always_comb begin
        pick_dma = dma_req_valid &&
                   (!cpu_req_valid || (DMA_PRIO != 0) || !gnt_dma);
    end

    // NOTE: every register here is a plain flop (no memory array), so all of
    // them take the async reset; state is only ever updated with <= so that
    // the whole FSM sees pre-edge values within one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            gnt_dma      <= 1'b0;
            sdr_in_valid <= 1'b0;
            sdr_addr     <= '0;
            sdr_rw       <= 1'b0;
            sdr_wdata    <= '0;
            rdata_q      <= '0;
            cpu_req_ack  <= 1'b0;
            dma_req_ack  <= 1'b0;
        end else begin
            // Acks default low so any assertion below lasts exactly one cycle.
            cpu_req_ack <= 1'b0;
            dma_req_ack <= 1'b0;

            case (state)
                IDLE: begin
                    if (cpu_req_valid || dma_req_valid) begin
                        gnt_dma      <= pick_dma;
                        sdr_addr     <= pick_dma ? dma_req_addr  : cpu_req_addr;
                        sdr_rw       <= pick_dma ? dma_req_rw    : cpu_req_rw;
                        sdr_wdata    <= pick_dma ? dma_req_wdata : cpu_req_wdata;
                        sdr_in_valid <= 1'b1;
                        state        <= ISSUE;
                    end
                end

                ISSUE: begin
                    // Command registers are left untouched here, so they stay
                    // stable under back-pressure and hold after acceptance.
                    if (sdr_ready) begin
                        sdr_in_valid <= 1'b0;
                        if (sdr_rw) begin
                            cpu_req_ack <= !gnt_dma;
                            dma_req_ack <= gnt_dma;
                            state       <= ACK;
                        end else begin
                            state <= WAIT_RD;
                        end
                    end
                end

                WAIT_RD: begin
                    // Only this state listens to the return strobe; strays in
                    // any other state are dropped.
                    if (sdr_out_valid) begin
                        rdata_q     <= sdr_rdata;
                        cpu_req_ack <= !gnt_dma;
                        dma_req_ack <= gnt_dma;
                        state       <= ACK;
                    end
                end

                ACK: begin
                    // Requests are not sampled here, so a valid still high
                    // from the just-acked request cannot be granted twice.
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign cpu_rsp_rdata = rdata_q;
    assign dma_rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sdr_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdr_req_arbiter
//   Self-checking bench for sdr_req_arbiter. A transaction-level reference
//   model predicts every output on every cycle. Hand-computed literal checks
//   pin the reset state, the quoted latencies, the grant orders and the
//   reset-abort behaviour. A second instance with DMA_PRIO=1 covers DMA
//   priority.
// -----------------------------------------------------------------------------
module tb_sdr_req_arbiter;

    localparam int ADDR_W   = 23;
    localparam int DATA_W   = 32;
    localparam int WAIT_MAX = 200;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              rw;
        logic [DATA_W-1:0] wdata;
        int                gap;
    } op_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- main DUT (round-robin) ----------------
    logic              cpu_req_valid, cpu_req_rw, cpu_req_ack;
    logic [ADDR_W-1:0] cpu_req_addr;
    logic [DATA_W-1:0] cpu_req_wdata, cpu_rsp_rdata;
    logic              dma_req_valid, dma_req_rw, dma_req_ack;
    logic [ADDR_W-1:0] dma_req_addr;
    logic [DATA_W-1:0] dma_req_wdata, dma_rsp_rdata;
    logic              sdr_in_valid, sdr_rw, sdr_ready, sdr_out_valid, gnt_dma;
    logic [ADDR_W-1:0] sdr_addr;
    logic [DATA_W-1:0] sdr_wdata, sdr_rdata;

    sdr_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DMA_PRIO(0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr),
        .cpu_req_rw(cpu_req_rw), .cpu_req_wdata(cpu_req_wdata),
        .cpu_req_ack(cpu_req_ack), .cpu_rsp_rdata(cpu_rsp_rdata),
        .dma_req_valid(dma_req_valid), .dma_req_addr(dma_req_addr),
        .dma_req_rw(dma_req_rw), .dma_req_wdata(dma_req_wdata),
        .dma_req_ack(dma_req_ack), .dma_rsp_rdata(dma_rsp_rdata),
        .sdr_in_valid(sdr_in_valid), .sdr_addr(sdr_addr), .sdr_rw(sdr_rw),
        .sdr_wdata(sdr_wdata), .sdr_ready(sdr_ready),
        .sdr_out_valid(sdr_out_valid), .sdr_rdata(sdr_rdata),
        .gnt_dma(gnt_dma)
    );

    // ---------------- second DUT (DMA priority) ----------------
    logic              p_cpu_req_valid, p_cpu_req_rw, p_cpu_req_ack;
    logic [ADDR_W-1:0] p_cpu_req_addr;
    logic [DATA_W-1:0] p_cpu_req_wdata, p_cpu_rsp_rdata;
    logic              p_dma_req_valid, p_dma_req_rw, p_dma_req_ack;
    logic [ADDR_W-1:0] p_dma_req_addr;
    logic [DATA_W-1:0] p_dma_req_wdata, p_dma_rsp_rdata;
    logic              p_sdr_in_valid, p_sdr_rw, p_sdr_ready, p_sdr_out_valid, p_gnt_dma;
    logic [ADDR_W-1:0] p_sdr_addr;
    logic [DATA_W-1:0] p_sdr_wdata, p_sdr_rdata;

    sdr_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DMA_PRIO(1)) u_dut_prio (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(p_cpu_req_valid), .cpu_req_addr(p_cpu_req_addr),
        .cpu_req_rw(p_cpu_req_rw), .cpu_req_wdata(p_cpu_req_wdata),
        .cpu_req_ack(p_cpu_req_ack), .cpu_rsp_rdata(p_cpu_rsp_rdata),
        .dma_req_valid(p_dma_req_valid), .dma_req_addr(p_dma_req_addr),
        .dma_req_rw(p_dma_req_rw), .dma_req_wdata(p_dma_req_wdata),
        .dma_req_ack(p_dma_req_ack), .dma_rsp_rdata(p_dma_rsp_rdata),
        .sdr_in_valid(p_sdr_in_valid), .sdr_addr(p_sdr_addr), .sdr_rw(p_sdr_rw),
        .sdr_wdata(p_sdr_wdata), .sdr_ready(p_sdr_ready),
        .sdr_out_valid(p_sdr_out_valid), .sdr_rdata(p_sdr_rdata),
        .gnt_dma(p_gnt_dma)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    function automatic op_t mk_op(input logic [ADDR_W-1:0] a, input logic rw,
                                  input logic [DATA_W-1:0] d, input int gap);
        op_t o;
        o.addr  = a;
        o.rw    = rw;
        o.wdata = d;
        o.gap   = gap;
        return o;
    endfunction

    // ---------------- requester drivers ----------------
    op_t cpu_q[$], dma_q[$];
    op_t cpu_op, dma_op;
    bit  cpu_busy = 0, dma_busy = 0;
    int  cpu_n, dma_n;

    initial begin
        cpu_req_valid = 0; cpu_req_addr = '0; cpu_req_rw = 0; cpu_req_wdata = '0;
        @(posedge clk); #1;
        forever begin
            if (cpu_q.size() == 0 || !rst_n) begin
                cpu_req_valid = 0;
                cpu_busy      = 0;
                @(posedge clk); #1;
            end else begin
                cpu_op        = cpu_q.pop_front();
                cpu_busy      = 1;
                cpu_req_valid = 1;
                cpu_req_addr  = cpu_op.addr;
                cpu_req_rw    = cpu_op.rw;
                cpu_req_wdata = cpu_op.wdata;
                cpu_n = 0;
                do begin @(negedge clk); cpu_n++; end
                while (!cpu_req_ack && rst_n && cpu_n < WAIT_MAX);
                if (rst_n) check("cpu_ack_timeout", 64'(cpu_req_ack), 64'd1);
                @(posedge clk); #1;
                if (cpu_op.gap > 0) begin
                    cpu_req_valid = 0;
                    repeat (cpu_op.gap) @(posedge clk);
                    #1;
                end
            end
        end
    end

    initial begin
        dma_req_valid = 0; dma_req_addr = '0; dma_req_rw = 0; dma_req_wdata = '0;
        @(posedge clk); #1;
        forever begin
            if (dma_q.size() == 0 || !rst_n) begin
                dma_req_valid = 0;
                dma_busy      = 0;
                @(posedge clk); #1;
            end else begin
                dma_op        = dma_q.pop_front();
                dma_busy      = 1;
                dma_req_valid = 1;
                dma_req_addr  = dma_op.addr;
                dma_req_rw    = dma_op.rw;
                dma_req_wdata = dma_op.wdata;
                dma_n = 0;
                do begin @(negedge clk); dma_n++; end
                while (!dma_req_ack && rst_n && dma_n < WAIT_MAX);
                if (rst_n) check("dma_ack_timeout", 64'(dma_req_ack), 64'd1);
                @(posedge clk); #1;
                if (dma_op.gap > 0) begin
                    dma_req_valid = 0;
                    repeat (dma_op.gap) @(posedge clk);
                    #1;
                end
            end
        end
    end

    // ---------------- SDRAM controller responder ----------------
    int   stall_n = 0;           // ready held low for this many cycles of a command
    bit   rdy_rand = 0;
    int   lat_min = 1, lat_max = 1;
    bit   stray_en = 0;
    bit   fix_en = 0;
    logic [DATA_W-1:0] fix_data = '0;
    int   acc_cnt = 0;
    bit   rsp_pend = 0;
    int   rsp_cnt = 0;
    int   age = 0;
    bit   s_acc, s_rd;
    logic [ADDR_W-1:0] acc_log[$];

    initial begin
        sdr_ready = 0; sdr_out_valid = 0; sdr_rdata = '0;
        forever begin
            @(negedge clk);
            s_acc = rst_n && sdr_in_valid && sdr_ready;
            s_rd  = !sdr_rw;
            if (s_acc) begin
                acc_cnt++;
                acc_log.push_back(sdr_addr);
            end
            age = (rst_n && sdr_in_valid) ? age + 1 : 0;
            @(posedge clk); #1;
            if (s_acc && s_rd) begin
                rsp_pend = 1;
                rsp_cnt  = $urandom_range(lat_max, lat_min);
            end
            sdr_out_valid = 0;
            if (rsp_pend) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    sdr_out_valid = 1;
                    sdr_rdata     = fix_en ? fix_data : $urandom;
                    rsp_pend      = 0;
                end
            end else if (stray_en && $urandom_range(7, 0) == 0) begin
                sdr_out_valid = 1;
                sdr_rdata     = $urandom;
            end
            sdr_ready = rdy_rand ? ($urandom_range(2, 0) != 0) : (age >= stall_n);
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    // Transaction view: a request is "pending issue" until accepted, then
    // (reads only) "awaiting data", then owes one ack cycle; only a free cycle
    // with no transaction in hand samples the requesters.
    bit                m_busy = 0, m_acc = 0, m_ack_due = 0, m_take_dma;
    logic              m_dma = 0, m_rw = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_wdata = '0, m_rdata = '0;
    int                vld_cycles = 0, cpu_acks = 0, dma_acks = 0;
    bit                gnt_log[$];

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            m_busy = 0; m_acc = 0; m_ack_due = 0;
            m_dma = 0; m_rw = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        end
        check("sdr_in_valid", 64'(sdr_in_valid), 64'(m_busy && !m_acc));
        check("acks", 64'({cpu_req_ack, dma_req_ack}),
              64'({m_ack_due && !m_dma, m_ack_due && m_dma}));
        check("cmd", 64'({sdr_addr, sdr_rw, sdr_wdata}), 64'({m_addr, m_rw, m_wdata}));
        check("gnt_dma", 64'(gnt_dma), 64'(m_dma));
        check("rsp_rdata", {cpu_rsp_rdata, dma_rsp_rdata}, {m_rdata, m_rdata});

        if (rst_n) begin
            if (sdr_in_valid) vld_cycles++;
            if (cpu_req_ack) begin cpu_acks++; gnt_log.push_back(1'b0); end
            if (dma_req_ack) begin dma_acks++; gnt_log.push_back(1'b1); end

            if (m_ack_due) begin
                m_ack_due = 0;
                m_busy    = 0;
            end else if (!m_busy) begin
                if (cpu_req_valid || dma_req_valid) begin
                    // Round-robin: on conflict, whoever was not served last.
                    m_take_dma = dma_req_valid && (!cpu_req_valid || !m_dma);
                    m_dma   = m_take_dma;
                    m_addr  = m_take_dma ? dma_req_addr  : cpu_req_addr;
                    m_rw    = m_take_dma ? dma_req_rw    : cpu_req_rw;
                    m_wdata = m_take_dma ? dma_req_wdata : cpu_req_wdata;
                    m_busy  = 1;
                    m_acc   = 0;
                end
            end else if (!m_acc) begin
                if (sdr_ready) begin
                    m_acc     = 1;
                    m_ack_due = m_rw;
                end
            end else if (sdr_out_valid) begin
                m_rdata   = sdr_rdata;
                m_ack_due = 1;
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while ((cpu_q.size() != 0 || dma_q.size() != 0 || cpu_busy || dma_busy ||
                m_busy || rsp_pend) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(n < 20000), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    int base, k;

    initial begin
        rst_n = 0;
        p_cpu_req_valid = 0; p_cpu_req_addr = '0; p_cpu_req_rw = 0; p_cpu_req_wdata = '0;
        p_dma_req_valid = 0; p_dma_req_addr = '0; p_dma_req_rw = 0; p_dma_req_wdata = '0;
        p_sdr_ready = 1; p_sdr_out_valid = 0; p_sdr_rdata = '0;

        repeat (3) @(negedge clk);
        check("reset_valid_ack", 64'({sdr_in_valid, cpu_req_ack, dma_req_ack, gnt_dma}), 64'd0);
        check("reset_cmd", 64'({sdr_addr, sdr_rw, sdr_wdata}), 64'd0);
        @(posedge clk); #3;
        rst_n = 1;
        repeat (2) @(negedge clk);

        // T1: DMA read, data returned 3 cycles after accept -> ack in cycle 5.
        lat_min = 3; lat_max = 3; fix_en = 1; fix_data = 32'hDEAD_BEEF;
        base = cpu_acks;
        dma_q.push_back(mk_op(23'h000100, 1'b0, 32'h0, 0));
        repeat (5) @(negedge clk);
        check("t1_ack_early", 64'(dma_req_ack), 64'd0);
        @(negedge clk);
        check("t1_ack", 64'(dma_req_ack), 64'd1);
        check("t1_rdata", 64'(dma_rsp_rdata), 64'h0000_0000_DEAD_BEEF);
        @(negedge clk);
        check("t1_ack_one_cycle", 64'(dma_req_ack), 64'd0);
        wait_idle("t1_idle");
        check("t1_no_cpu_ack", 64'(cpu_acks - base), 64'd0);
        fix_en = 0;

        // T2: CPU write with ready already high.
        cpu_q.push_back(mk_op(23'h000040, 1'b1, 32'h1234_5678, 0));
        @(negedge clk);
        check("t2_c0_valid", 64'(sdr_in_valid), 64'd0);
        @(negedge clk);
        check("t2_c1_valid", 64'(sdr_in_valid), 64'd1);
        check("t2_c1_cmd", 64'({sdr_addr, sdr_rw, sdr_wdata}),
              64'({23'h000040, 1'b1, 32'h1234_5678}));
        @(negedge clk);
        check("t2_c2_ack", 64'(cpu_req_ack), 64'd1);
        wait_idle("t2_idle");

        // T3: simultaneous conflict, round-robin, last grant was CPU.
        lat_min = 1; lat_max = 4;
        gnt_log.delete();
        for (int i = 0; i < 2; i++) begin
            cpu_q.push_back(mk_op(23'h000400 + 23'(i), 1'($urandom), $urandom, 0));
            dma_q.push_back(mk_op(23'h000800 + 23'(i), 1'($urandom), $urandom, 0));
        end
        wait_idle("t3_idle");
        check("t3_count", 64'(gnt_log.size()), 64'd4);
        k = 0;
        foreach (gnt_log[i]) k = (k << 1) | int'(gnt_log[i]);
        check("t3_order", 64'(k), 64'b1010);

        // T3b: DMA priority instance, CPU starves while DMA stays valid.
        @(posedge clk); #1;
        p_cpu_req_valid = 1; p_cpu_req_addr = 23'h0000C0; p_cpu_req_rw = 1; p_cpu_req_wdata = 32'hC0C0_C0C0;
        p_dma_req_valid = 1; p_dma_req_rw = 1; p_dma_req_wdata = 32'hD0D0_D0D0;
        for (int i = 0; i < 4; i++) begin
            p_dma_req_addr = 23'h000300 + 23'(i);
            k = 0;
            do begin @(negedge clk); k++; end
            while (!(p_cpu_req_ack || p_dma_req_ack) && k < 20);
            check("t3p_dma_ack", 64'({p_cpu_req_ack, p_dma_req_ack, p_gnt_dma}), 64'b011);
            check("t3p_addr", 64'(p_sdr_addr), 64'(23'h000300 + 23'(i)));
            @(posedge clk); #1;
        end
        p_dma_req_valid = 0;
        k = 0;
        do begin @(negedge clk); k++; end
        while (!(p_cpu_req_ack || p_dma_req_ack) && k < 20);
        check("t3p_cpu_ack", 64'({p_cpu_req_ack, p_dma_req_ack, p_gnt_dma}), 64'b100);
        check("t3p_cpu_addr", 64'(p_sdr_addr), 64'h0C0);
        @(posedge clk); #1;
        p_cpu_req_valid = 0;

        // T4: back-pressure, ready low for the first 5 cycles of the command.
        @(negedge clk);
        stall_n = 5;
        vld_cycles = 0;
        base = acc_cnt;
        cpu_q.push_back(mk_op(23'h001234, 1'b1, 32'hA5A5_5A5A, 0));
        wait_idle("t4_idle");
        check("t4_valid_cycles", 64'(vld_cycles), 64'd6);
        check("t4_accepts", 64'(acc_cnt - base), 64'd1);
        stall_n = 0;

        // T5: DMA streaming reads, new address the cycle after each ack.
        acc_log.delete();
        base = dma_acks;
        for (int i = 0; i < 8; i++)
            dma_q.push_back(mk_op(23'h002000 + 23'(4 * i), 1'b0, 32'h0, 0));
        wait_idle("t5_idle");
        check("t5_acks", 64'(dma_acks - base), 64'd8);
        check("t5_cmds", 64'(acc_log.size()), 64'd8);
        foreach (acc_log[i])
            check("t5_addr", 64'(acc_log[i]), 64'(23'h002000 + 23'(4 * i)));

        // Random traffic: random ready, latency, gaps, stray strobes.
        rdy_rand = 1; stray_en = 1; lat_min = 1; lat_max = 5;
        for (int i = 0; i < 150; i++) begin
            cpu_q.push_back(mk_op(23'($urandom), 1'($urandom), $urandom, int'($urandom_range(3, 0))));
            dma_q.push_back(mk_op(23'($urandom), 1'($urandom), $urandom, int'($urandom_range(2, 0))));
        end
        wait_idle("rand_idle");
        rdy_rand = 0; stray_en = 0;
        @(negedge clk);

        // T6: reset while waiting for read data; the late strobe must be ignored.
        lat_min = 6; lat_max = 6; fix_en = 1; fix_data = 32'hBAD0_0BAD;
        dma_q.push_back(mk_op(23'h003000, 1'b0, 32'h0, 0));
        k = 0;
        while (!rsp_pend && k < 50) begin @(negedge clk); k++; end
        check("t6_read_accepted", 64'(rsp_pend), 64'd1);
        @(posedge clk); #3;
        rst_n = 0;
        repeat (2) @(negedge clk);
        check("t6_reset_outputs", 64'({sdr_in_valid, cpu_req_ack, dma_req_ack, gnt_dma}), 64'd0);
        check("t6_reset_cmd", 64'({sdr_addr, sdr_rw, sdr_wdata}), 64'd0);
        @(posedge clk); #3;
        rst_n = 1;
        base = dma_acks + cpu_acks;
        k = 0;
        while (rsp_pend && k < 50) begin @(negedge clk); k++; end
        repeat (4) @(negedge clk);
        check("t6_no_ack", 64'(dma_acks + cpu_acks - base), 64'd0);
        check("t6_rdata_kept", 64'(dma_rsp_rdata), 64'd0);
        fix_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
